i2c_init_sequencer: RTL and testbench

- Upstream command source for the I2C controller in the video path.
- On a start pulse, walks a table of configuration entries held in an external synchronous ROM: single-byte register writes and wait delays.
- Issues each write to the controller over its ready/valid command interface and waits for bus completion before fetching the next entry.
- Used to bring up the video encoder/codec after power-on without CPU involvement.

---
 rtl/i2c_init_sequencer.sv | 176 +++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_sequencer.sv
// Walks a ROM table of single-byte I2C register writes and delays into the I2C controller after a start pulse.
// Define I2C_SEQ_TIMEOUT_EN to add a watchdog that abandons the table if the controller stalls.
module i2c_init_sequencer #(
   parameter int ROM_AW  = 8,
   parameter int DELAY_W = 24
`ifdef I2C_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1 << 20
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   output logic [15:0]       i2c_slave_addr,
   output logic [15:0]       i2c_reg_addr,
   output logic [15:0]       i2c_wdata,
   output logic              i2c_ctrl_valid,
   input  logic              i2c_ctrl_ready,
   output logic              busy,
   output logic              done,
   output logic [ROM_AW:0]   entries_done
`ifdef I2C_SEQ_TIMEOUT_EN
   ,
   output logic              timeout
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_BUSY,
      S_WAIT_DONE, S_DELAY, S_ADVANCE, S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DELAY_W-1:0] r_dly_cnt;
   logic               w_start;
   logic               w_finish;
   logic               w_load_wr;
   logic               w_load_dly;
   logic               w_inc_ent;
   logic               w_addr_inc;
   logic               w_unused;

   assign w_unused = &{1'b0, rom_data[5:0]};

`ifdef I2C_SEQ_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [WDOG_W-1:0] r_wdog;
   logic              w_wdog_run;
   logic              w_wdog_hit;

   assign w_wdog_run = (r_state == S_ISSUE) || (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
   assign w_wdog_hit = w_wdog_run && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_start        = 1'b0;
      w_finish       = 1'b0;
      w_load_wr      = 1'b0;
      w_load_dly     = 1'b0;
      w_inc_ent      = 1'b0;
      w_addr_inc     = 1'b0;
      i2c_ctrl_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start     = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: begin
            // END wins over DELAY when both flags are set
            if (rom_data[7]) begin
               w_finish    = 1'b1;
               w_state_nxt = S_DONE;
            end else if (rom_data[6]) begin
               w_load_dly  = 1'b1;
               w_state_nxt = S_DELAY;
            end else begin
               w_load_wr   = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            i2c_ctrl_valid = 1'b1;
            if (i2c_ctrl_ready) w_state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: if (!i2c_ctrl_ready) w_state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (i2c_ctrl_ready) begin
               w_inc_ent   = 1'b1;
               w_state_nxt = S_ADVANCE;
            end
         end
         // a loaded count of 0 falls out after one cycle, same as 1
         S_DELAY: if (r_dly_cnt <= DELAY_W'(1)) w_state_nxt = S_ADVANCE;
         S_ADVANCE: begin
            if (&rom_addr) begin
               w_finish    = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_addr_inc  = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
`ifdef I2C_SEQ_TIMEOUT_EN
      if (w_wdog_hit) begin
         i2c_ctrl_valid = 1'b0;
         w_inc_ent      = 1'b0;
         w_finish       = 1'b1;
         w_state_nxt    = S_DONE;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr       <= '0;
         i2c_slave_addr <= '0;
         i2c_reg_addr   <= '0;
         i2c_wdata      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         entries_done   <= '0;
         r_dly_cnt      <= '0;
      end else begin
         if (w_start) begin
            rom_addr     <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            entries_done <= '0;
         end
         if (w_addr_inc) rom_addr <= rom_addr + ROM_AW'(1);
         if (w_finish) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
         if (w_inc_ent && (entries_done != '1)) entries_done <= entries_done + (ROM_AW + 1)'(1);
         // fields stay put after the handshake; the controller latches them later
         if (w_load_wr) begin
            i2c_slave_addr <= {8'h00, rom_data[31:25], 1'b0};
            i2c_reg_addr   <= {8'h01, rom_data[23:16]};
            i2c_wdata      <= {8'h00, rom_data[15:8]};
         end
         if (w_load_dly)              r_dly_cnt <= rom_data[DELAY_W+7:8];
         else if (r_state == S_DELAY) r_dly_cnt <= r_dly_cnt - DELAY_W'(1);
      end
   end

`ifdef I2C_SEQ_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wdog  <= '0;
         timeout <= 1'b0;
      end else begin
         if (w_start)    timeout <= 1'b0;
         if (w_wdog_hit) timeout <= 1'b1;
         if (w_load_wr)       r_wdog <= '0;
         else if (w_wdog_run) r_wdog <= r_wdog + WDOG_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench: a table model predicts each handshake and its start-to-issue gap; a controller model checks them.
module tb_i2c_init_sequencer;
   localparam int AW = 2;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_data;
   logic [15:0]   i2c_slave_addr, i2c_reg_addr, i2c_wdata;
   logic          i2c_ctrl_valid;
   logic          i2c_ctrl_ready;
   logic          busy, done;
   logic [AW:0]   entries_done;
`ifdef I2C_SEQ_TIMEOUT_EN
   logic          timeout;
`endif

   always #5 clk = ~clk;

   i2c_init_sequencer #(
      .ROM_AW(AW), .DELAY_W(24)
`ifdef I2C_SEQ_TIMEOUT_EN
      , .TIMEOUT_CYCLES(64)
`endif
   ) dut (
      .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .i2c_slave_addr(i2c_slave_addr), .i2c_reg_addr(i2c_reg_addr), .i2c_wdata(i2c_wdata),
      .i2c_ctrl_valid(i2c_ctrl_valid), .i2c_ctrl_ready(i2c_ctrl_ready),
      .busy(busy), .done(done), .entries_done(entries_done)
`ifdef I2C_SEQ_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   logic [31:0] rom [N];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] sa;
      logic [15:0] ra;
      logic [15:0] wd;
      int          gap;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int passes = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
   endtask

   // controller model state
   int          busy_len  = 5;
   int          busy_cnt  = 0;
   bit          pending   = 0;
   bit          stuck     = 0;
   bit          skip_hold = 0;
   bit          hold_ok   = 1;
   int          hs_cnt    = 0;
   int          last_evt  = 0;
   logic [47:0] latched;

   always @(negedge clk) begin
      if (!stuck) begin
         if (busy_cnt > 0) begin
            if (i2c_ctrl_valid !== 1'b0) hold_ok = 0;
            if (!skip_hold && ({i2c_slave_addr, i2c_reg_addr, i2c_wdata} !== latched)) hold_ok = 0;
            busy_cnt--;
            if (busy_cnt == 0) begin
               i2c_ctrl_ready = 1'b1;
               last_evt       = cyc;
               skip_hold      = 0;
               chk("hold_and_single_valid", hold_ok, 1);
            end
         end else if (pending) begin
            pending        = 0;
            hold_ok        = (i2c_ctrl_valid === 1'b0);
            i2c_ctrl_ready = 1'b0;
            busy_cnt       = (busy_len == 0) ? $urandom_range(1, 20) : busy_len;
         end else if (i2c_ctrl_valid === 1'b1 && i2c_ctrl_ready === 1'b1) begin
            exp_t e;
            hs_cnt++;
            chk("handshake_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("fields", {i2c_slave_addr, i2c_reg_addr, i2c_wdata}, {e.sa, e.ra, e.wd});
               chk("issue_gap", cyc - last_evt, e.gap);
            end
            latched = {i2c_slave_addr, i2c_reg_addr, i2c_wdata};
            pending = 1;
         end
      end
   end

   task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
      rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
   endtask

   // Table semantics: writes in order until END or table end; each entry after the first
   // costs a 3-cycle fetch, a delay adds its count (min 1), first issue 3 cycles after start.
   task automatic build_expect(output int ed, output int la);
      int          gap;
      int          d;
      logic [31:0] e;
      exp_t        x;
      gap = 3; ed = 0; la = N - 1;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         e = rom[i];
         if (e[7]) begin
            la = i;
            break;
         end else if (e[6]) begin
            d   = int'(e[31:8]);
            gap = gap + 3 + ((d == 0) ? 1 : d);
         end else begin
            x.sa  = {8'h00, e[31:25], 1'b0};
            x.ra  = {8'h01, e[23:16]};
            x.wd  = {8'h00, e[15:8]};
            x.gap = gap;
            exp_q.push_back(x);
            gap = 4;
            ed++;
         end
      end
      if (ed > 7) ed = 7;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start    = 1'b1;
      last_evt = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_table(input int blen, input bit busy_start);
      int ed, la, t;
      build_expect(ed, la);
      busy_len = blen;
      pulse_start();
      chk("busy_after_start", busy, 1);
      chk("done_cleared", done, 0);
`ifdef I2C_SEQ_TIMEOUT_EN
      chk("timeout_cleared", timeout, 0);
`endif
      t = 0;
      while (done !== 1'b1 && t < 5000) begin
         @(negedge clk);
         t++;
         start = busy_start && (t == 15);
      end
      start = 1'b0;
      chk("done_reached", done, 1);
      chk("busy_at_done", busy, 0);
      chk("entries_done", entries_done, ed);
      chk("final_rom_addr", rom_addr, la);
      chk("writes_left", exp_q.size(), 0);
   endtask

   function automatic logic [31:0] rand_entry();
      int          k = $urandom_range(0, 9);
      logic [31:0] v = $urandom;
      if (k == 0) v[7] = 1'b1;
      else if (k <= 2) begin
         v[31:8] = 24'($urandom_range(0, 20));
         v[7:6]  = 2'b01;
      end else v[7:6] = 2'b00;
      return v;
   endfunction

   initial begin
      #900000;
      $display("FAIL global_time_limit: got cycle %0d, expected finish earlier", cyc);
      $fatal(1);
   end

   initial begin
      int t, base, s;
      reset = 1'b1; start = 1'b0; i2c_ctrl_ready = 1'b1;
      load(32'h0, 32'h0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", i2c_ctrl_valid, 0);
      chk("rst_busy_done", {busy, done}, 0);
      chk("rst_addr_cnt", {rom_addr, entries_done}, 0);
      chk("rst_fields", {i2c_slave_addr, i2c_reg_addr, i2c_wdata}, 0);

      // single write then END
      load(32'h72083500, 32'h00000080, 32'h11111100, 32'h22222200);
      run_table(5, 0);
      // three writes, slow controller, END with DELAY bit also set
      load(32'h10203000, 32'h40506000, 32'h70809000, 32'h000000C0);
      run_table(50, 0);
      // delay 100 and delay 0 between writes
      load(32'h50010100, 32'h00006440, 32'h50020200, 32'h00000080);
      run_table(3, 0);
      load(32'h50030300, 32'h00000040, 32'h50040400, 32'h00000080);
      run_table(3, 0);

      // reset while waiting on entry 2
      load(32'h60010100, 32'h62020200, 32'h64030300, 32'h00000080);
      begin
         int ed, la;
         build_expect(ed, la);
      end
      busy_len = 30;
      base     = hs_cnt;
      pulse_start();
      t = 0;
      while (!(hs_cnt == base + 2 && busy_cnt > 5 && busy_cnt < 25) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("reached_entry2", hs_cnt - base, 2);
      reset     = 1'b1;
      skip_hold = 1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_valid", i2c_ctrl_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_addr", rom_addr, 0);
      chk("midrst_cnt_done", {entries_done, done}, 0);
      exp_q.delete();
      t = 0;
      while (!(i2c_ctrl_ready && busy_cnt == 0 && !pending) && t < 200) begin
         @(negedge clk);
         t++;
      end
      run_table(0, 0);

      // full table with no END, plus a start pulse while busy
      load(32'hA5112200, 32'h20334400, 32'h21556600, 32'h40778800);
      run_table(20, 1);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < N; i++) rom[i] = rand_entry();
         run_table(0, 0);
      end

`ifdef I2C_SEQ_TIMEOUT_EN
      load(32'h72083500, 32'h00000080, 32'h0, 32'h0);
      exp_q.delete();
      stuck          = 1;
      i2c_ctrl_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      s     = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc - s < 66) @(negedge clk);
      chk("timeout_not_early", {timeout, done}, 0);
      @(negedge clk);
      chk("timeout_at_64", {timeout, done, i2c_ctrl_valid, busy}, 4'b1100);
      i2c_ctrl_ready = 1'b1;
      stuck          = 0;
      load(32'h72083500, 32'h00000080, 32'h0, 32'h0);
      run_table(5, 0);
`else
      s = 0;
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
